md_unit: RTL and testbench

Multi-cycle multiply/divide unit with its own HI/LO registers. It sits in the EX stage beside the ALU and accepts one operation per start pulse. While an operation runs it holds `Busy` high; the hazard unit uses `Busy` to stall later mult/div/mfhi/mflo instructions in D. It also handles MTHI/MTLO writes to HI and LO.

---
 rtl/md_unit.sv | 149 ++++++++++++++
 tb/tb_md_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with private HI/LO registers.
// Ports:
//   clk, reset (async, active-low)
//   A, B    : rs / rt operands, latched on acceptance
//   MDOp    : 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   Start   : request strobe, sampled with MDOp/A/B
//   Cancel  : suppresses a request in the same cycle
//   Busy    : registered, high exactly N cycles per mult/div
//   HI, LO  : architectural HI/LO registers
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  input  logic        Cancel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    op_q, op_n;
  logic [31:0]   a_q, a_n, b_q, b_n;
  logic          busy_n;
  logic [31:0]   hi_n, lo_n;

  // Result datapath, driven only from the latched operands.
  logic        is_signed;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag, quot, rem;

  always_comb begin
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    a_ext     = {{32{is_signed & a_q[31]}}, a_q};
    b_ext     = {{32{is_signed & b_q[31]}}, b_q};
    // Low 64 bits of the extended product are correct for both signednesses.
    prod      = a_ext * b_ext;
    // Sign-magnitude divide: truncates toward zero and makes the
    // 0x80000000 / -1 case fall out as LO=0x80000000, HI=0.
    a_neg     = is_signed & a_q[31];
    b_neg     = is_signed & b_q[31];
    a_mag     = a_neg ? 32'(32'd0 - a_q) : a_q;
    b_mag     = b_neg ? 32'(32'd0 - b_q) : b_q;
    div_b     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag     = a_mag / div_b;
    r_mag     = a_mag % div_b;
    quot      = (a_neg ^ b_neg) ? 32'(32'd0 - q_mag) : q_mag;
    rem       = a_neg ? 32'(32'd0 - r_mag) : r_mag;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    busy_n  = Busy;
    hi_n    = HI;
    lo_n    = LO;
    case (state)
      IDLE: begin
        if (Start && !Cancel) begin
          case (MDOp)
            OP_MTHI: hi_n = A;
            OP_MTLO: lo_n = A;
            OP_MULT, OP_MULTU: begin
              op_n    = MDOp;
              a_n     = A;
              b_n     = B;
              cnt_n   = CW'(MULT_CYCLES);
              busy_n  = 1'b1;
              state_n = RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_n    = MDOp;
              a_n     = A;
              b_n     = B;
              cnt_n   = CW'(DIV_CYCLES);
              busy_n  = 1'b1;
              state_n = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
            hi_n = prod[63:32];
            lo_n = prod[31:0];
          end else if (b_q != 32'd0) begin
            // Divide by zero leaves HI/LO untouched.
            hi_n = rem;
            lo_n = quot;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      Busy  <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      a_q   <= a_n;
      b_q   <= b_n;
      Busy  <= busy_n;
      HI    <= hi_n;
      LO    <= lo_n;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDOp;
  logic        Start, Cancel;
  logic        Busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp),
    .Start(Start), .Cancel(Cancel), .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request for one cycle; called on a negedge, returns on the next.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp  = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    MDOp  = 3'd0;
  endtask

  // Count negedges with Busy high, bounded at 200.
  task automatic wait_busy(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #3;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
    total++; if (HI !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=00000000", HI); end
    total++; if (LO !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=00000000", LO); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int n;
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    total++; if (HI !== 32'd0 || LO !== 32'd0) begin bad++; $display("FAIL mult_hold got=%h_%h want=0_0", HI, LO); end
    wait_busy(n);
    total++; if (n !== 5) begin bad++; $display("FAIL mult_busy got=%0d want=5", n); end
    total++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_res got=%h_%h want=ffffffff_fffffffa", HI, LO); end
  endtask

  task automatic test_multu;
    int n;
    issue(3'd2, 32'hFFFFFFFE, 32'd3);
    wait_busy(n);
    total++; if (n !== 5) begin bad++; $display("FAIL multu_busy got=%0d want=5", n); end
    total++; if (HI !== 32'h2 || LO !== 32'hFFFFFFFA) begin bad++; $display("FAIL multu_res got=%h_%h want=00000002_fffffffa", HI, LO); end
  endtask

  task automatic test_div;
    int n;
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_busy(n);
    total++; if (n !== 10) begin bad++; $display("FAIL div_busy got=%0d want=10", n); end
    total++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_res got=%h_%h want=ffffffff_fffffffd", HI, LO); end
  endtask

  task automatic test_divu;
    int n;
    issue(3'd4, 32'd7, 32'd2);
    wait_busy(n);
    total++; if (n !== 10) begin bad++; $display("FAIL divu_busy got=%0d want=10", n); end
    total++; if (HI !== 32'd1 || LO !== 32'd3) begin bad++; $display("FAIL divu_res got=%h_%h want=00000001_00000003", HI, LO); end
  endtask

  task automatic test_div_ovf;
    int n;
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_busy(n);
    total++; if (HI !== 32'd0 || LO !== 32'h80000000) begin bad++; $display("FAIL div_ovf got=%h_%h want=00000000_80000000", HI, LO); end
  endtask

  task automatic test_div_zero;
    int n;
    issue(3'd5, 32'h11, 32'd0);
    total++; if (Busy !== 1'b0 || HI !== 32'h11) begin bad++; $display("FAIL mthi got busy=%b hi=%h want 0/00000011", Busy, HI); end
    issue(3'd6, 32'h22, 32'd0);
    total++; if (Busy !== 1'b0 || LO !== 32'h22) begin bad++; $display("FAIL mtlo got busy=%b lo=%h want 0/00000022", Busy, LO); end
    issue(3'd4, 32'd5, 32'd0);
    wait_busy(n);
    total++; if (n !== 10) begin bad++; $display("FAIL divz_busy got=%0d want=10", n); end
    total++; if (HI !== 32'h11 || LO !== 32'h22) begin bad++; $display("FAIL divz_res got=%h_%h want=00000011_00000022", HI, LO); end
  endtask

  task automatic test_cancel;
    int n;
    Cancel = 1'b1;
    issue(3'd1, 32'd5, 32'd5);
    Cancel = 1'b0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b want=0", Busy); end
    @(negedge clk);
    total++; if (Busy !== 1'b0 || HI !== 32'h11 || LO !== 32'h22) begin bad++; $display("FAIL cancel_hold got=%b %h_%h want 0 00000011_00000022", Busy, HI, LO); end
    issue(3'd1, 32'd7, 32'hFFFFFFFF);
    Cancel = 1'b1;
    wait_busy(n);
    Cancel = 1'b0;
    total++; if (n !== 5) begin bad++; $display("FAIL cancel_mid_busy got=%0d want=5", n); end
    total++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFF9) begin bad++; $display("FAIL cancel_mid_res got=%h_%h want=ffffffff_fffffff9", HI, LO); end
  endtask

  task automatic test_run_ignore;
    int n;
    issue(3'd4, 32'd100, 32'd7);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (Busy !== 1'b1) break;
      n++;
      A     = 32'hDEAD ^ (32'(i) * 32'h01010101);
      B     = 32'(i);
      MDOp  = (i == 3) ? 3'd5 : 3'd1;
      Start = (i == 3 || i == 5) ? 1'b1 : 1'b0;
      if (i == 3) A = 32'hDEAD;
      @(negedge clk);
    end
    Start = 1'b0;
    MDOp  = 3'd0;
    total++; if (n !== 10) begin bad++; $display("FAIL run_busy got=%0d want=10", n); end
    total++; if (HI !== 32'd2 || LO !== 32'd14) begin bad++; $display("FAIL run_res got=%h_%h want=00000002_0000000e", HI, LO); end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(3'd2, 32'h80000000, 32'd4);
    repeat (4) @(negedge clk);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL b2b_last_run got=%b want=1", Busy); end
    MDOp = 3'd4; A = 32'hFFFFFFFF; B = 32'h10; Start = 1'b1;
    @(negedge clk);
    total++; if (Busy !== 1'b0 || HI !== 32'd2 || LO !== 32'd0) begin bad++; $display("FAIL b2b_done got=%b %h_%h want 0 00000002_00000000", Busy, HI, LO); end
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0;
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", Busy); end
    wait_busy(n);
    total++; if (n !== 10) begin bad++; $display("FAIL b2b_busy got=%0d want=10", n); end
    total++; if (HI !== 32'hF || LO !== 32'h0FFFFFFF) begin bad++; $display("FAIL b2b_res got=%h_%h want=0000000f_0fffffff", HI, LO); end
  endtask

  task automatic test_async_reset;
    int n;
    issue(3'd5, 32'h55, 32'd0);
    issue(3'd6, 32'h66, 32'd0);
    total++; if (HI !== 32'h55 || LO !== 32'h66) begin bad++; $display("FAIL ar_preload got=%h_%h want=00000055_00000066", HI, LO); end
    issue(3'd3, 32'd100, 32'd3);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin bad++; $display("FAIL ar_async got=%b %h_%h want 0 00000000_00000000", Busy, HI, LO); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin bad++; $display("FAIL ar_after got=%b %h_%h want 0 00000000_00000000", Busy, HI, LO); end
    issue(3'd2, 32'h10000, 32'h10000);
    wait_busy(n);
    total++; if (n !== 5) begin bad++; $display("FAIL ar_multu_busy got=%0d want=5", n); end
    total++; if (HI !== 32'd1 || LO !== 32'd0) begin bad++; $display("FAIL ar_multu_res got=%h_%h want=00000001_00000000", HI, LO); end
  endtask

  initial begin
    reset  = 1'b0;
    A      = 32'd0;
    B      = 32'd0;
    MDOp   = 3'd0;
    Start  = 1'b0;
    Cancel = 1'b0;
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_divu;
    test_div_ovf;
    test_div_zero;
    test_cancel;
    test_run_ignore;
    test_back_to_back;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
